// File: rtl/vga_buf_arbiter.sv
// Write-side controller for the VGA text buffer.
// Host character writes share the buffer write port with a clear/fill engine
// that overwrites every buffer word with one character. When both want the
// port in the same cycle they take turns. Every buffer write leaves through
// one register stage, so both sources have a latency of one cycle.
module vga_buf_arbiter #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int BUF_ADDR_WIDTH   = 10,
    parameter int N_WORDS          = 600,
    parameter int CLR_IN_BLANK     = 1
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          host_wvalid_i,
    output logic                          host_wready_o,
    input  logic [BUF_ADDR_WIDTH-1:0]     host_waddr_i,
    input  logic [C_AXI_DATA_WIDTH-1:0]   host_wdata_i,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] host_wstrb_i,
    output logic                          host_err_o,
    input  logic                          clr_start_i,
    input  logic [6:0]                    clr_char_i,
    input  logic                          blank_i,
    output logic                          clr_busy_o,
    output logic                          clr_done_o,
    output logic                          buf_wr_en_o,
    output logic [BUF_ADDR_WIDTH-1:0]     buf_waddr_o,
    output logic [C_AXI_DATA_WIDTH-1:0]   buf_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0] buf_wstrb_o
);

    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic GNT_HOST = 1'b0;
    localparam logic GNT_ENG  = 1'b1;

    // Highest buffer word in use; host addresses above it are dropped.
    localparam logic [BUF_ADDR_WIDTH-1:0] LAST_ADDR = BUF_ADDR_WIDTH'(N_WORDS - 1);

    logic [0:0]                  state_q, state_d;
    logic [BUF_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [6:0]                  char_q, char_d;
    logic                        last_grant_q, last_grant_d;
    logic                        wr_en_q, wr_en_d;
    logic [BUF_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]           wstrb_q, wstrb_d;
    logic                        err_q, err_d;
    logic                        done_q, done_d;

    logic                        eng_req;
    logic                        grant_eng;
    logic                        host_acc;
    logic                        host_in_range;
    logic [C_AXI_DATA_WIDTH-1:0] fill_word;

    // Fill word: the latched character in every byte lane, lane MSB forced to 0.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_fill_lane
            assign fill_word[gi*8 +: 8] = {1'b0, char_q};
        end
    endgenerate

    // Arbitration. The engine only asks while clearing (and, if configured,
    // only during blanking). On a contested cycle the side that lost the
    // previous contest wins, so the host waits at most one cycle.
    always_comb begin
        eng_req       = (state_q == ST_CLEAR) && ((CLR_IN_BLANK == 0) || blank_i);
        grant_eng     = eng_req && (!host_wvalid_i || (last_grant_q == GNT_HOST));
        host_wready_o = rstn_i && !grant_eng;
        host_acc      = host_wvalid_i && host_wready_o;
        host_in_range = (host_waddr_i <= LAST_ADDR);
    end

    // Next-state: buffer write selection, fill counter, FSM and round-robin memory.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        char_d       = char_q;
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        err_d        = 1'b0;
        done_d       = 1'b0;

        if (host_acc) begin
            if (host_in_range) begin
                wr_en_d = 1'b1;
                waddr_d = host_waddr_i;
                wdata_d = host_wdata_i;
                wstrb_d = host_wstrb_i;
            end else begin
                err_d = 1'b1;
            end
        end else if (grant_eng) begin
            wr_en_d = 1'b1;
            waddr_d = cnt_q;
            wdata_d = fill_word;
            wstrb_d = '1;
            if (cnt_q == LAST_ADDR) begin
                // Last word issued: leave CLEAR now, counter parks at the top.
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Remember the winner only when both sides actually competed.
        if (eng_req && host_wvalid_i) begin
            last_grant_d = grant_eng ? GNT_ENG : GNT_HOST;
        end

        // A start is only honoured from IDLE; grant_eng is 0 there, so this
        // never collides with the engine branch above.
        if ((state_q == ST_IDLE) && clr_start_i) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            char_d  = clr_char_i;
        end
    end

    // State and output registers; reset aborts any fill in progress.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            char_q       <= '0;
            last_grant_q <= GNT_ENG;
            wr_en_q      <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            char_q       <= char_d;
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    assign clr_busy_o  = (state_q == ST_CLEAR);
    assign clr_done_o  = done_q;
    assign host_err_o  = err_q;
    assign buf_wr_en_o = wr_en_q;
    assign buf_waddr_o = waddr_q;
    assign buf_wdata_o = wdata_q;
    assign buf_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_vga_buf_arbiter.sv
// Directed bench for vga_buf_arbiter: a table of single host beats in IDLE,
// then hand-written sequences for fills, contested fills, blank-gated fills
// and reset in the middle of a fill.
module tb_vga_buf_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        host_wvalid;
    logic        host_wready;
    logic [9:0]  host_waddr;
    logic [31:0] host_wdata;
    logic [3:0]  host_wstrb;
    logic        host_err;
    logic        clr_start;
    logic [6:0]  clr_char;
    logic        blank;
    logic        clr_busy;
    logic        clr_done;
    logic        buf_wr_en;
    logic [9:0]  buf_waddr;
    logic [31:0] buf_wdata;
    logic [3:0]  buf_wstrb;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    vga_buf_arbiter #(
        .C_AXI_DATA_WIDTH(32),
        .BUF_ADDR_WIDTH  (10),
        .N_WORDS         (600),
        .CLR_IN_BLANK    (1)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .host_wvalid_i(host_wvalid),
        .host_wready_o(host_wready),
        .host_waddr_i (host_waddr),
        .host_wdata_i (host_wdata),
        .host_wstrb_i (host_wstrb),
        .host_err_o   (host_err),
        .clr_start_i  (clr_start),
        .clr_char_i   (clr_char),
        .blank_i      (blank),
        .clr_busy_o   (clr_busy),
        .clr_done_o   (clr_done),
        .buf_wr_en_o  (buf_wr_en),
        .buf_waddr_o  (buf_waddr),
        .buf_wdata_o  (buf_wdata),
        .buf_wstrb_o  (buf_wstrb)
    );

    typedef struct {
        logic        wvalid;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        ex_wready;
        logic        ex_wr_en;
        logic [9:0]  ex_addr;
        logic [31:0] ex_data;
        logic [3:0]  ex_strb;
        logic        ex_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Uncontested fill with blank held high; optionally keeps clr_start
    // asserted with another character during the fill, which must be ignored.
    task automatic run_fill(input logic [6:0] ch, input bit chatter);
        int          n_w = 0;
        int          n_bad = 0;
        int          n_done = 0;
        int          busy_cyc = 0;
        int          done_cyc = -1;
        int          last_cyc = -1;
        logic [9:0]  exp_a = '0;
        logic [31:0] word;
        word = {4{1'b0, ch}};
        @(negedge clk);
        host_wvalid = 1'b0;
        blank       = 1'b1;
        clr_start   = 1'b1;
        clr_char    = ch;
        for (int cyc = 0; cyc < 610; cyc++) begin
            @(posedge clk); #1;
            if (clr_busy) busy_cyc++;
            if (buf_wr_en) begin
                n_w++;
                if (buf_waddr !== exp_a || buf_wdata !== word || buf_wstrb !== 4'hF) n_bad++;
                if (buf_waddr == 10'd599) last_cyc = cyc;
                exp_a++;
            end
            if (clr_done) begin
                n_done++;
                done_cyc = cyc;
            end
            @(negedge clk);
            if (chatter && cyc < 10) begin
                clr_start = 1'b1;
                clr_char  = ch ^ 7'h13;
            end else begin
                clr_start = 1'b0;
            end
        end
        $display("fill char=0x%0h: writes=%0d bad=%0d busy=%0d done=%0d@%0d last@%0d",
                 ch, n_w, n_bad, busy_cyc, n_done, done_cyc, last_cyc);
        check("fill_writes", n_w, 600);
        check("fill_bad_words", n_bad, 0);
        check("fill_busy_cycles", busy_cyc, 600);
        check("fill_done_count", n_done, 1);
        check("fill_done_cycle", done_cyc, 600);
        check("fill_last_write_cycle", last_cyc, 600);
    endtask

    initial begin
        int eng_n, host_n, bad_n, idle_n, run, max_run, done_cyc, host_miss, bad_blank;
        logic [9:0] exp_a;
        logic       blank_drv;
        bit         seen300;

        //              wv  addr     data           strb   rdy wr  eaddr    edata          estrb  err
        vecs[0] = '{1'b1, 10'd5,    32'h41424344, 4'hF, 1'b1, 1'b1, 10'd5,   32'h41424344, 4'hF, 1'b0};
        vecs[1] = '{1'b0, 10'd9,    32'h00000000, 4'h0, 1'b1, 1'b0, 10'd5,   32'h41424344, 4'hF, 1'b0};
        vecs[2] = '{1'b1, 10'd600,  32'hDEADBEEF, 4'h3, 1'b1, 1'b0, 10'd5,   32'h41424344, 4'hF, 1'b1};
        vecs[3] = '{1'b1, 10'd599,  32'h11223344, 4'h5, 1'b1, 1'b1, 10'd599, 32'h11223344, 4'h5, 1'b0};
        vecs[4] = '{1'b1, 10'd1023, 32'h00000000, 4'hF, 1'b1, 1'b0, 10'd599, 32'h11223344, 4'h5, 1'b1};
        vecs[5] = '{1'b1, 10'd0,    32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, 10'd0,   32'hFFFFFFFF, 4'h0, 1'b0};
        vecs[6] = '{1'b0, 10'd0,    32'h00000000, 4'h0, 1'b1, 1'b0, 10'd0,   32'hFFFFFFFF, 4'h0, 1'b0};

        // Reset with a host beat pending: everything, including wready, is 0.
        rstn = 1'b0; host_wvalid = 1'b1; host_waddr = 10'd3; host_wdata = 32'h55555555;
        host_wstrb = 4'hF; clr_start = 1'b0; clr_char = 7'h00; blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("reset: wready=%0b wr_en=%0b busy=%0b", host_wready, buf_wr_en, clr_busy);
        check("rst_wready", host_wready, 0);
        check("rst_wr_en", buf_wr_en, 0);
        check("rst_addr", buf_waddr, 0);
        check("rst_data", buf_wdata, 0);
        check("rst_strb", buf_wstrb, 0);
        check("rst_err", host_err, 0);
        check("rst_busy", clr_busy, 0);
        check("rst_done", clr_done, 0);
        @(negedge clk);
        rstn = 1'b1; host_wvalid = 1'b0;

        // Single host beats in IDLE.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            host_wvalid = vecs[i].wvalid;
            host_waddr  = vecs[i].waddr;
            host_wdata  = vecs[i].wdata;
            host_wstrb  = vecs[i].wstrb;
            #1;
            check("vec_wready", host_wready, vecs[i].ex_wready);
            @(posedge clk); #1;
            $display("vec %0d: v=%0b a=%0d -> wr_en=%0b addr=%0d data=0x%h strb=0x%h err=%0b",
                     i, vecs[i].wvalid, vecs[i].waddr, buf_wr_en, buf_waddr, buf_wdata, buf_wstrb, host_err);
            check("vec_wr_en", buf_wr_en, vecs[i].ex_wr_en);
            check("vec_addr", buf_waddr, vecs[i].ex_addr);
            check("vec_data", buf_wdata, vecs[i].ex_data);
            check("vec_strb", buf_wstrb, vecs[i].ex_strb);
            check("vec_err", host_err, vecs[i].ex_err);
            check("vec_busy", clr_busy, 0);
        end
        @(negedge clk);
        host_wvalid = 1'b0;

        // Uncontested fill with space characters, start chatter during CLEAR.
        run_fill(7'h20, 1'b1);

        // Host valid held for the whole fill: host and engine alternate.
        @(negedge clk);
        host_wvalid = 1'b1; host_waddr = 10'd100; host_wdata = 32'hCAFEBABE; host_wstrb = 4'hF;
        blank = 1'b1; clr_start = 1'b1; clr_char = 7'h41;
        eng_n = 0; host_n = 0; bad_n = 0; idle_n = 0; run = 0; max_run = 0; done_cyc = -1;
        exp_a = '0;
        for (int cyc = 0; cyc < 1300; cyc++) begin
            @(posedge clk); #1;
            if (!buf_wr_en) begin
                idle_n++;
            end else if (buf_waddr == 10'd100 && buf_wdata == 32'hCAFEBABE) begin
                host_n++;
                run = 0;
            end else if (buf_waddr == exp_a && buf_wdata == 32'h41414141 && buf_wstrb == 4'hF) begin
                eng_n++;
                exp_a++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                bad_n++;
            end
            if (clr_done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            clr_start = 1'b0;
        end
        @(negedge clk);
        host_wvalid = 1'b0;
        $display("contested fill: eng=%0d host=%0d bad=%0d idle=%0d max_eng_run=%0d done@%0d",
                 eng_n, host_n, bad_n, idle_n, max_run, done_cyc);
        check("cont_eng_writes", eng_n, 600);
        check("cont_host_writes", host_n, 601);
        check("cont_bad", bad_n, 0);
        check("cont_idle", idle_n, 0);
        check("cont_max_eng_run", max_run, 1);
        check("cont_done_cycle", done_cyc, 1200);

        // Blank-gated fill with host traffic, interrupted by reset at word 300.
        @(negedge clk);
        host_wvalid = 1'b1; host_waddr = 10'd7; host_wdata = 32'h12345678; host_wstrb = 4'h3;
        blank = 1'b0; clr_start = 1'b1; clr_char = 7'h2E;
        @(posedge clk); #1;
        eng_n = 0; host_n = 0; bad_n = 0; idle_n = 0; host_miss = 0; bad_blank = 0;
        exp_a = '0; seen300 = 1'b0;
        for (int k = 1; k < 3000; k++) begin
            @(negedge clk);
            clr_start = 1'b0;
            blank_drv = (k % 3 != 0);
            blank     = blank_drv;
            @(posedge clk); #1;
            if (!buf_wr_en) begin
                idle_n++;
            end else if (buf_waddr == 10'd7 && buf_wdata == 32'h12345678) begin
                host_n++;
            end else if (buf_waddr == exp_a && buf_wdata == 32'h2E2E2E2E) begin
                eng_n++;
                if (!blank_drv) bad_blank++;
                if (buf_waddr == 10'd300) seen300 = 1'b1;
                exp_a++;
            end else begin
                bad_n++;
            end
            if (!blank_drv && !(buf_wr_en && buf_waddr == 10'd7 && buf_wdata == 32'h12345678))
                host_miss++;
            if (seen300) break;
        end
        $display("blank fill: eng=%0d host=%0d bad=%0d idle=%0d eng_in_active=%0d host_miss=%0d",
                 eng_n, host_n, bad_n, idle_n, bad_blank, host_miss);
        check("blank_reached_300", seen300, 1);
        check("blank_eng_in_active", bad_blank, 0);
        check("blank_host_miss", host_miss, 0);
        check("blank_idle", idle_n, 0);
        check("blank_bad", bad_n, 0);

        #1;
        rstn = 1'b0;
        #1;
        $display("mid-fill reset: wready=%0b wr_en=%0b busy=%0b addr=%0d",
                 host_wready, buf_wr_en, clr_busy, buf_waddr);
        check("abort_wready", host_wready, 0);
        check("abort_wr_en", buf_wr_en, 0);
        check("abort_addr", buf_waddr, 0);
        check("abort_data", buf_wdata, 0);
        check("abort_strb", buf_wstrb, 0);
        check("abort_busy", clr_busy, 0);
        check("abort_done", clr_done, 0);
        check("abort_err", host_err, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_hold", {buf_wr_en, clr_done, clr_busy}, 0);
        end
        @(negedge clk);
        rstn = 1'b1; host_wvalid = 1'b0; blank = 1'b1;
        @(posedge clk); #1;
        check("after_abort_no_done", clr_done, 0);

        // Restart after the abort fills the whole buffer again.
        run_fill(7'h5A, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
